// File: rtl/gpmc_pkg.sv
// Shared definitions for the synchronous GPMC target: FSM states, sampled
// control-strobe bundle, default read-error pattern and register-map word addresses.
package gpmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_HOLD = 3'd3,
        ST_DONE    = 3'd4
    } gpmc_state_e;

    // Active-low GPMC control strobes as sampled on one gpmc_clk edge.
    typedef struct packed {
        logic csn;
        logic advn;
        logic wen;
        logic oen;
    } gpmc_ctrl_t;

    localparam logic [15:0] RD_ERR_DATA_DEFAULT = 16'hBAD0;

    localparam logic [15:0] REG_ID_WADDR         = 16'h0000;
    localparam logic [15:0] REG_SCRATCH_WADDR    = 16'h0001;
    localparam logic [15:0] REG_HBLANK_WADDR     = 16'h000A;
    localparam logic [15:0] REG_PIXEL_FIFO_WADDR = 16'h0800;

    function automatic logic is_read_state(gpmc_state_e s);
        return (s == ST_RD_WAIT) || (s == ST_RD_HOLD);
    endfunction

endpackage

// File: rtl/gpmc_sync_target.sv
// Synchronous muxed-AD GPMC responder: turns host bursts into single-word
// register-bus read/write strobes and drives read data back onto the AD pad.
module gpmc_sync_target
    import gpmc_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned RD_TIMEOUT  = 2,
    parameter logic [15:0] RD_ERR_DATA = RD_ERR_DATA_DEFAULT
) (
    input  logic              gpmc_clk,
    input  logic              glbl_reset,
    input  logic [15:0]       gpmc_ad_in,
    output logic [15:0]       gpmc_ad_out,
    output logic              gpmc_ad_oe,
    input  logic              gpmc_csn1,
    input  logic              gpmc_advn,
    input  logic              gpmc_wein,
    input  logic              gpmc_oen,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wr_en,
    output logic [15:0]       bus_wr_data,
    output logic              bus_rd_en,
    input  logic [15:0]       bus_rd_data,
    input  logic              bus_rd_valid,
    output logic              rd_timeout_err
);

    localparam int unsigned      CNT_W    = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    gpmc_ctrl_t ctrl;

    gpmc_state_e       state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [15:0]       wr_data_q,   wr_data_d;
    logic              wr_en_q,     wr_en_d;
    logic              rd_en_q,     rd_en_d;
    logic [15:0]       ad_out_q,    ad_out_d;
    logic              ad_oe_q,     ad_oe_d;
    logic              tmo_err_q,   tmo_err_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    assign ctrl = '{csn: gpmc_csn1, advn: gpmc_advn, wen: gpmc_wein, oen: gpmc_oen};

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        ad_out_d  = ad_out_q;
        tmo_err_d = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (!ctrl.csn && !ctrl.advn) begin
                    addr_d  = gpmc_ad_in[ADDR_W-1:0];
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (ctrl.csn) begin
                    state_d = ST_IDLE;
                end else if (!ctrl.advn) begin
                    addr_d = gpmc_ad_in[ADDR_W-1:0];
                end else if (!ctrl.wen) begin
                    // Write wins over a simultaneous OE.
                    wr_data_d = gpmc_ad_in;
                    wr_en_d   = 1'b1;
                    state_d   = ST_DONE;
                end else if (!ctrl.oen) begin
                    rd_en_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                if (ctrl.csn) begin
                    state_d = ST_IDLE;
                end else if (bus_rd_valid) begin
                    ad_out_d = bus_rd_data;
                    state_d  = ST_RD_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    ad_out_d  = RD_ERR_DATA;
                    tmo_err_d = 1'b1;
                    state_d   = ST_RD_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RD_HOLD: begin
                // Any bus_rd_valid seen here is a late response and is ignored.
                if (ctrl.csn) begin
                    state_d = ST_IDLE;
                end else if (ctrl.oen) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (ctrl.csn) begin
                    state_d = ST_IDLE;
                end else if (!ctrl.advn) begin
                    addr_d  = gpmc_ad_in[ADDR_W-1:0];
                    state_d = ST_ADDR;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        ad_oe_d = !ctrl.oen && !ctrl.csn && ctrl.wen && is_read_state(state_d);
    end

    always_ff @(posedge gpmc_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (glbl_reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            ad_out_q  <= '0;
            ad_oe_q   <= 1'b0;
            tmo_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            ad_out_q  <= ad_out_d;
            ad_oe_q   <= ad_oe_d;
            tmo_err_q <= tmo_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gpmc_ad_out    = ad_out_q;
    assign gpmc_ad_oe     = ad_oe_q;
    assign bus_addr       = addr_q;
    assign bus_wr_en      = wr_en_q;
    assign bus_wr_data    = wr_data_q;
    assign bus_rd_en      = rd_en_q;
    assign rd_timeout_err = tmo_err_q;

endmodule

// File: tb/tb_gpmc_sync_target.sv
// Self-checking bench for gpmc_sync_target: host bus-functional tasks, a register-file
// responder, a table of directed vectors, corner sequences and a randomized phase.
module tb_gpmc_sync_target;

    localparam logic [15:0] ERR_DATA = 16'hBAD0;

    logic        clk = 1'b0;
    logic        glbl_reset = 1'b1;
    logic [15:0] ad_in = '0;
    logic [15:0] ad_out;
    logic        ad_oe;
    logic        csn = 1'b1, advn = 1'b1, wein = 1'b1, oen = 1'b1;
    logic [15:0] bus_addr;
    logic        bus_wr_en;
    logic [15:0] bus_wr_data;
    logic        bus_rd_en;
    logic [15:0] bus_rd_data = '0;
    logic        bus_rd_valid = 1'b0;
    logic        rd_timeout_err;

    gpmc_sync_target #(.ADDR_W(16), .RD_TIMEOUT(2), .RD_ERR_DATA(ERR_DATA)) dut (
        .gpmc_clk      (clk),
        .glbl_reset    (glbl_reset),
        .gpmc_ad_in    (ad_in),
        .gpmc_ad_out   (ad_out),
        .gpmc_ad_oe    (ad_oe),
        .gpmc_csn1     (csn),
        .gpmc_advn     (advn),
        .gpmc_wein     (wein),
        .gpmc_oen      (oen),
        .bus_addr      (bus_addr),
        .bus_wr_en     (bus_wr_en),
        .bus_wr_data   (bus_wr_data),
        .bus_rd_en     (bus_rd_en),
        .bus_rd_data   (bus_rd_data),
        .bus_rd_valid  (bus_rd_valid),
        .rd_timeout_err(rd_timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of what the host believes the register file holds.
    logic [15:0] ref_mem [logic [15:0]];
    // Downstream register file, updated only by the DUT's write strobes.
    logic [15:0] dev_mem [logic [15:0]];

    int          wr_cnt = 0, rd_cnt = 0, tmo_cnt = 0;
    logic [31:0] wr_q[$];
    int          resp_lat = 2;      // 0 = silent, else edges after bus_rd_en rises
    int          pend_cnt = 0;
    logic [15:0] pend_data = '0;
    bit          stray_req = 1'b0;

    function automatic logic [15:0] ref_rd(input logic [15:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : 16'h0000;
    endfunction

    function automatic logic [15:0] dev_rd(input logic [15:0] w);
        return dev_mem.exists(w) ? dev_mem[w] : 16'h0000;
    endfunction

    // Monitor and responder, acting half a cycle away from the DUT's edge.
    always @(negedge clk) begin
        bus_rd_valid = 1'b0;
        if (pend_cnt != 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus_rd_valid = 1'b1;
                bus_rd_data  = pend_data;
            end
        end
        if (stray_req) begin
            stray_req    = 1'b0;
            bus_rd_valid = 1'b1;
            bus_rd_data  = 16'hDEAD;
        end
        if (bus_wr_en) begin
            wr_cnt++;
            wr_q.push_back({bus_addr, bus_wr_data});
            dev_mem[bus_addr] = bus_wr_data;
        end
        if (rd_timeout_err) tmo_cnt++;
        if (bus_rd_en) begin
            rd_cnt++;
            if (resp_lat == 1) begin
                bus_rd_valid = 1'b1;
                bus_rd_data  = dev_rd(bus_addr);
            end else if (resp_lat > 1) begin
                pend_cnt  = resp_lat - 1;
                pend_data = dev_rd(bus_addr);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic host_write(input logic [15:0] word, input logic [15:0] data,
                              input bit keep_cs, input bit both, input string tag);
        int wr0 = wr_cnt;
        int rd0 = rd_cnt;
        csn = 1'b0; advn = 1'b0; ad_in = word;
        tick();
        advn = 1'b1; wein = 1'b0; oen = both ? 1'b0 : 1'b1; ad_in = data;
        tick();
        check({tag, ".wr_en"},   32'(bus_wr_en),   32'd1);
        check({tag, ".addr"},    32'(bus_addr),    32'(word));
        check({tag, ".wr_data"}, 32'(bus_wr_data), 32'(data));
        check({tag, ".oe"},      32'(ad_oe),       32'd0);
        wein = 1'b1; oen = 1'b1; ad_in = '0;
        if (!keep_cs) csn = 1'b1;
        tick();
        check({tag, ".wr_en_clr"}, 32'(bus_wr_en), 32'd0);
        check({tag, ".wr_pulses"}, 32'(wr_cnt - wr0), 32'd1);
        check({tag, ".rd_pulses"}, 32'(rd_cnt - rd0), 32'd0);
    endtask

    task automatic host_read(input logic [15:0] word, input int lat, input logic [15:0] exp,
                             input bit stray, input string tag);
        int rd0  = rd_cnt;
        int tmo0 = tmo_cnt;
        resp_lat = lat;
        csn = 1'b0; advn = 1'b0; ad_in = word;
        tick();
        advn = 1'b1; oen = 1'b0; ad_in = '0;
        tick();
        check({tag, ".rd_en"}, 32'(bus_rd_en), 32'd1);
        check({tag, ".oe_on"}, 32'(ad_oe),     32'd1);
        tick();
        tick();
        // Host samples here: three edges after OE was first seen low.
        check({tag, ".rd_data"}, 32'(ad_out),         32'(exp));
        check({tag, ".tmo"},     32'(rd_timeout_err), 32'(lat == 0));
        check({tag, ".oe_hold"}, 32'(ad_oe),          32'd1);
        if (stray) begin
            stray_req = 1'b1;
            tick();
            tick();
            check({tag, ".stray_data"}, 32'(ad_out), 32'(exp));
            check({tag, ".stray_oe"},   32'(ad_oe),  32'd1);
        end
        oen = 1'b1;
        tick();
        check({tag, ".oe_off"}, 32'(ad_oe), 32'd0);
        csn = 1'b1;
        tick();
        check({tag, ".rd_pulses"},  32'(rd_cnt - rd0),   32'd1);
        check({tag, ".tmo_pulses"}, 32'(tmo_cnt - tmo0), 32'(lat == 0));
    endtask

    typedef struct {
        bit          is_wr;
        bit          both;
        logic [16:0] byte_addr;
        logic [15:0] wdata;
        int          lat;
        bit          stray;
        logic [15:0] exp_word;
        logic [15:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t        vecs[6];
        logic [15:0] burst[4];
        int          wr0, rd0;

        vecs[0] = '{1'b1, 1'b0, 17'h00002, 16'h4321, 0, 1'b0, 16'h0001, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 17'h00000, 16'h0000, 2, 1'b0, 16'h0000, 16'h1234};
        vecs[2] = '{1'b0, 1'b0, 17'h00002, 16'h0000, 1, 1'b0, 16'h0001, 16'h4321};
        vecs[3] = '{1'b0, 1'b0, 17'h00014, 16'h0000, 0, 1'b1, 16'h000A, 16'hBAD0};
        vecs[4] = '{1'b1, 1'b1, 17'h00014, 16'h5555, 0, 1'b0, 16'h000A, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 17'h00014, 16'h0000, 2, 1'b0, 16'h000A, 16'h5555};

        ref_mem[16'h0000] = 16'h1234;
        dev_mem[16'h0000] = 16'h1234;

        repeat (3) @(negedge clk);
        check("rst.ad_out",  32'(ad_out),         32'd0);
        check("rst.ad_oe",   32'(ad_oe),          32'd0);
        check("rst.addr",    32'(bus_addr),       32'd0);
        check("rst.wr_en",   32'(bus_wr_en),      32'd0);
        check("rst.wr_data", 32'(bus_wr_data),    32'd0);
        check("rst.rd_en",   32'(bus_rd_en),      32'd0);
        check("rst.tmo",     32'(rd_timeout_err), 32'd0);
        glbl_reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            string tag = $sformatf("vec%0d", i);
            check({tag, ".word"}, 32'(vecs[i].byte_addr[16:1]), 32'(vecs[i].exp_word));
            if (vecs[i].is_wr) begin
                host_write(vecs[i].byte_addr[16:1], vecs[i].wdata, 1'b0, vecs[i].both, tag);
                ref_mem[vecs[i].exp_word] = vecs[i].wdata;
            end else begin
                host_read(vecs[i].byte_addr[16:1], vecs[i].lat, vecs[i].exp_rdata, vecs[i].stray, tag);
            end
        end

        // Four back-to-back writes in one chip-select, re-addressed from DONE.
        for (int i = 0; i < 4; i++) burst[i] = 16'($urandom);
        wr_q.delete();
        for (int i = 0; i < 4; i++)
            host_write(16'h0800, burst[i], i != 3, 1'b0, $sformatf("burst%0d", i));
        ref_mem[16'h0800] = burst[3];
        check("burst.count", 32'(wr_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_q.size(); i++)
            check($sformatf("burst.q%0d", i), wr_q[i], {16'h0800, burst[i]});

        // Abort after the address phase: strobes presented with CS high must be ignored.
        wr0 = wr_cnt; rd0 = rd_cnt;
        csn = 1'b0; advn = 1'b0; ad_in = 16'h0005;
        tick();
        advn = 1'b1; ad_in = '0;
        tick();
        csn = 1'b1; wein = 1'b0; oen = 1'b0;
        repeat (3) tick();
        wein = 1'b1; oen = 1'b1;
        tick();
        check("abort.wr_pulses", 32'(wr_cnt - wr0), 32'd0);
        check("abort.rd_pulses", 32'(rd_cnt - rd0), 32'd0);
        check("abort.oe",        32'(ad_oe),        32'd0);
        host_write(16'h0003, 16'hA5C3, 1'b0, 1'b0, "post_abort");
        ref_mem[16'h0003] = 16'hA5C3;

        // ADV held for two edges: the second address wins.
        csn = 1'b0; advn = 1'b0; ad_in = 16'h0111;
        tick();
        ad_in = 16'h0222;
        tick();
        advn = 1'b1; wein = 1'b0; ad_in = 16'h7E57;
        tick();
        check("relatch.addr",  32'(bus_addr),    32'h0222);
        check("relatch.wr_en", 32'(bus_wr_en),   32'd1);
        check("relatch.data",  32'(bus_wr_data), 32'h7E57);
        wein = 1'b1; csn = 1'b1; ad_in = '0;
        tick();
        ref_mem[16'h0222] = 16'h7E57;

        // Reset while the read data is being held on the pad.
        resp_lat = 2;
        csn = 1'b0; advn = 1'b0; ad_in = 16'h0000;
        tick();
        advn = 1'b1; oen = 1'b0;
        repeat (3) tick();
        check("rsthold.data", 32'(ad_out), 32'h1234);
        check("rsthold.oe",   32'(ad_oe),  32'd1);
        glbl_reset = 1'b1;
        tick();
        check("rsthold.oe_clr",  32'(ad_oe),          32'd0);
        check("rsthold.ad_out",  32'(ad_out),         32'd0);
        check("rsthold.addr",    32'(bus_addr),       32'd0);
        check("rsthold.wr_en",   32'(bus_wr_en),      32'd0);
        check("rsthold.wr_data", 32'(bus_wr_data),    32'd0);
        check("rsthold.rd_en",   32'(bus_rd_en),      32'd0);
        check("rsthold.tmo",     32'(rd_timeout_err), 32'd0);
        glbl_reset = 1'b0; csn = 1'b1; oen = 1'b1;
        repeat (2) tick();
        host_read(16'h0001, 2, ref_rd(16'h0001), 1'b0, "post_reset");

        // Randomized mix of reads and writes against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] w;
            logic [15:0] d;
            int          lat;
            string       tag = $sformatf("rnd%0d", i);
            case ($urandom_range(0, 3))
                0:       w = 16'h0001;
                1:       w = 16'h000A;
                2:       w = 16'h0800;
                default: w = 16'h0010 + 16'($urandom_range(0, 3));
            endcase
            d   = 16'($urandom);
            lat = int'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                host_write(w, d, 1'b0, 1'b0, tag);
                ref_mem[w] = d;
            end else begin
                host_read(w, lat, (lat == 0) ? ERR_DATA : ref_rd(w), 1'b0, tag);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
